// File: rtl/pixel_writer_pkg.sv
// Shared definitions for the pixel_writer drawing engine: op-codes, default
// screen geometry, datapath widths, FSM state encoding and a helper that
// returns how many operand bytes each op-code carries.
package pixel_writer_pkg;

    localparam int unsigned DEF_SCREEN_WIDTH  = 640;
    localparam int unsigned DEF_SCREEN_HEIGHT = 400;

    localparam int unsigned ADDR_W  = 18;
    localparam int unsigned COORD_W = 10;
    localparam int unsigned COLOR_W = 4;
    localparam int unsigned CNT_W   = 3;

    localparam logic [7:0] OP_SET_CURSOR  = 8'h10;
    localparam logic [7:0] OP_SET_COLOR   = 8'h11;
    localparam logic [7:0] OP_FILL_RECT   = 8'h12;
    localparam logic [7:0] OP_SHOW_BUFFER = 8'h14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FILL,
        ST_SWAP
    } state_t;

    // Operand bytes expected after an op-code; 0 for SHOW_BUFFER and unknown codes.
    function automatic logic [CNT_W-1:0] op_operand_count(input logic [7:0] op);
        case (op)
            OP_SET_CURSOR: return CNT_W'(4);
            OP_SET_COLOR:  return CNT_W'(1);
            OP_FILL_RECT:  return CNT_W'(4);
            default:       return CNT_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/rect_address_generator.sv
// Rectangle raster address generator.
// Loads origin and size on i_start, then emits one registered address per
// cycle (row-major) while i_ready is high. Row bases advance by SCREEN_WIDTH
// by addition. o_done_c is high once no pixel is pending and the last write
// has left the output register.
// Ports: i_clk, i_rst (sync, active-high), i_start, i_x/i_y origin,
//        i_w/i_h size, i_ready stall input, o_addr, o_en, o_done_c.
// Build option: PIXEL_WRITER_CLIP_EN clips the rectangle to the screen.
module rect_address_generator
    import pixel_writer_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = DEF_SCREEN_HEIGHT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [COORD_W-1:0] i_x,
    input  logic [COORD_W-1:0] i_y,
    input  logic [COORD_W-1:0] i_w,
    input  logic [COORD_W-1:0] i_h,
    input  logic               i_ready,
    output logic [ADDR_W-1:0]  o_addr,
    output logic               o_en,
    output logic               o_done_c
);

    logic [COORD_W-1:0] w_eff_w;
    logic [COORD_W-1:0] w_eff_h;
    logic [ADDR_W-1:0]  w_origin;

    logic               r_active;
    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_w;
    logic [COORD_W-1:0] r_h;
    logic [ADDR_W-1:0]  r_row_base;

    // Effective rectangle size after optional clipping.
    always_comb begin
        w_eff_w = i_w;
        w_eff_h = i_h;
`ifdef PIXEL_WRITER_CLIP_EN
        if (32'(i_x) >= SCREEN_WIDTH) begin
            w_eff_w = '0;
        end else if (32'(i_w) > SCREEN_WIDTH - 32'(i_x)) begin
            w_eff_w = COORD_W'(SCREEN_WIDTH - 32'(i_x));
        end
        if (32'(i_y) >= SCREEN_HEIGHT) begin
            w_eff_h = '0;
        end else if (32'(i_h) > SCREEN_HEIGHT - 32'(i_y)) begin
            w_eff_h = COORD_W'(SCREEN_HEIGHT - 32'(i_y));
        end
`endif
    end

`ifndef PIXEL_WRITER_CLIP_EN
    // Height only matters when clipping; keep the parameter referenced.
    logic [ADDR_W-1:0] w_frame_size_unused;
    assign w_frame_size_unused = ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT);
`endif

    // First pixel address, wrapped to the address width.
    assign w_origin = ADDR_W'(32'(i_y) * SCREEN_WIDTH + 32'(i_x));

    // Raster counters and registered address/enable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active   <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_row_base <= '0;
            o_addr     <= '0;
            o_en       <= 1'b0;
        end else if (i_start) begin
            r_active   <= (w_eff_w != '0) && (w_eff_h != '0);
            r_col      <= '0;
            r_row      <= '0;
            r_w        <= w_eff_w;
            r_h        <= w_eff_h;
            r_row_base <= w_origin;
            o_en       <= 1'b0;
        end else if (r_active && i_ready) begin
            o_addr <= r_row_base + ADDR_W'(r_col);
            o_en   <= 1'b1;
            if (r_col == r_w - COORD_W'(1)) begin
                r_col      <= '0;
                r_row_base <= r_row_base + ADDR_W'(SCREEN_WIDTH);
                if (r_row == r_h - COORD_W'(1)) begin
                    r_active <= 1'b0;
                end else begin
                    r_row <= r_row + COORD_W'(1);
                end
            end else begin
                r_col <= r_col + COORD_W'(1);
            end
        end else begin
            o_en <= 1'b0;
        end
    end

    assign o_done_c = !r_active && !o_en;

endmodule

// File: rtl/pixel_writer.sv
// Command-driven drawing engine for the frame buffer write side.
// Decodes the op-code/operand byte stream, holds cursor and color, rasterises
// FILL_RECT through rect_address_generator and pulses a buffer swap on
// SHOW_BUFFER.
// Ports: clock_in, reset_in (sync, active-high), op_code_in/op_code_valid_in,
//        operand_in/operand_valid_in, busy_out, pixel_write_address_out,
//        pixel_write_data_out, pixel_write_enable_out,
//        pixel_write_buffer_ready_in, switch_write_buffer_out.
// Build option: PIXEL_WRITER_CLIP_EN clips fills to the screen.
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int unsigned SCREEN_HEIGHT = DEF_SCREEN_HEIGHT
) (
    input  logic               clock_in,
    input  logic               reset_in,
    input  logic [7:0]         op_code_in,
    input  logic               op_code_valid_in,
    input  logic [7:0]         operand_in,
    input  logic               operand_valid_in,
    output logic               busy_out,
    output logic [ADDR_W-1:0]  pixel_write_address_out,
    output logic [COLOR_W-1:0] pixel_write_data_out,
    output logic               pixel_write_enable_out,
    input  logic               pixel_write_buffer_ready_in,
    output logic               switch_write_buffer_out
);

    state_t             r_state;
    state_t             w_state_next;
    logic [7:0]         r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_acc;
    logic [COORD_W-1:0] r_first;
    logic [COORD_W-1:0] r_cursor_x;
    logic [COORD_W-1:0] r_cursor_y;
    logic [COLOR_W-1:0] r_color;

    logic [COORD_W-1:0] w_value;
    logic               w_load_op;
    logic               w_take_operand;
    logic               w_capture_first;
    logic               w_set_cursor;
    logic               w_set_color;
    logic               w_fill_start;
    logic               w_gen_done_c;

    // 10-bit value formed by the previous (high) byte and the current byte.
    assign w_value = {r_acc, operand_in};

    // Next-state and control decode; an op-code strobe beats a same-cycle operand.
    always_comb begin
        w_state_next    = r_state;
        w_load_op       = 1'b0;
        w_take_operand  = 1'b0;
        w_capture_first = 1'b0;
        w_set_cursor    = 1'b0;
        w_set_color     = 1'b0;
        w_fill_start    = 1'b0;
        case (r_state)
            ST_IDLE, ST_COLLECT: begin
                if (op_code_valid_in) begin
                    w_load_op = 1'b1;
                    if (op_code_in == OP_SHOW_BUFFER) begin
                        w_state_next = ST_SWAP;
                    end else if (op_operand_count(op_code_in) != '0) begin
                        w_state_next = ST_COLLECT;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if ((r_state == ST_COLLECT) && operand_valid_in) begin
                    w_take_operand  = 1'b1;
                    w_capture_first = (r_cnt == CNT_W'(3));
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_next = ST_IDLE;
                        case (r_op)
                            OP_SET_CURSOR: w_set_cursor = 1'b1;
                            OP_SET_COLOR:  w_set_color  = 1'b1;
                            OP_FILL_RECT: begin
                                w_fill_start = 1'b1;
                                w_state_next = ST_FILL;
                            end
                            default: w_state_next = ST_IDLE;
                        endcase
                    end
                end
            end
            ST_FILL: begin
                if (w_gen_done_c) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SWAP: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State, command registers and registered status outputs.
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            r_state                 <= ST_IDLE;
            r_op                    <= '0;
            r_cnt                   <= '0;
            r_acc                   <= '0;
            r_first                 <= '0;
            r_cursor_x              <= '0;
            r_cursor_y              <= '0;
            r_color                 <= '0;
            busy_out                <= 1'b0;
            switch_write_buffer_out <= 1'b0;
            pixel_write_data_out    <= '0;
        end else begin
            r_state                 <= w_state_next;
            busy_out                <= (w_state_next == ST_FILL) || (w_state_next == ST_SWAP);
            switch_write_buffer_out <= (w_state_next == ST_SWAP);
            pixel_write_data_out    <= r_color;
            if (w_load_op) begin
                r_op  <= op_code_in;
                r_cnt <= op_operand_count(op_code_in);
            end else if (w_take_operand) begin
                r_acc <= operand_in[1:0];
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture_first) begin
                r_first <= w_value;
            end
            if (w_set_cursor) begin
                r_cursor_x <= r_first;
                r_cursor_y <= w_value;
            end
            if (w_set_color) begin
                r_color <= operand_in[COLOR_W-1:0];
            end
        end
    end

    rect_address_generator #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT)
    ) u_rect_address_generator (
        .i_clk    (clock_in),
        .i_rst    (reset_in),
        .i_start  (w_fill_start),
        .i_x      (r_cursor_x),
        .i_y      (r_cursor_y),
        .i_w      (r_first),
        .i_h      (w_value),
        .i_ready  (pixel_write_buffer_ready_in),
        .o_addr   (pixel_write_address_out),
        .o_en     (pixel_write_enable_out),
        .o_done_c (w_gen_done_c)
    );

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer. Expected writes come from a
// row-major rectangle model computed with plain arithmetic.
module tb_pixel_writer;

    localparam int SW = 640;
    localparam int SH = 400;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b0;
    logic [7:0]  op_code_in = 8'h00;
    logic        op_code_valid_in = 1'b0;
    logic [7:0]  operand_in = 8'h00;
    logic        operand_valid_in = 1'b0;
    logic        busy_out;
    logic [17:0] pixel_write_address_out;
    logic [3:0]  pixel_write_data_out;
    logic        pixel_write_enable_out;
    logic        pixel_write_buffer_ready_in = 1'b1;
    logic        switch_write_buffer_out;

    pixel_writer dut (
        .clock_in                    (clock_in),
        .reset_in                    (reset_in),
        .op_code_in                  (op_code_in),
        .op_code_valid_in            (op_code_valid_in),
        .operand_in                  (operand_in),
        .operand_valid_in            (operand_valid_in),
        .busy_out                    (busy_out),
        .pixel_write_address_out     (pixel_write_address_out),
        .pixel_write_data_out        (pixel_write_data_out),
        .pixel_write_enable_out      (pixel_write_enable_out),
        .pixel_write_buffer_ready_in (pixel_write_buffer_ready_in),
        .switch_write_buffer_out     (switch_write_buffer_out)
    );

    always #5 clock_in = ~clock_in;

    int cyc = 0;
    always @(posedge clock_in) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model state
    int m_x = 0, m_y = 0, m_color = 0;
    logic [17:0] exp_addr[$];

    // Monitor state
    logic [17:0] mon_addr[$];
    logic [3:0]  mon_data[$];
    int          mon_cyc[$];
    int          mon_busy = 0, mon_busy_first = -1;
    int          mon_sw = 0, mon_sw_first = -1;
    bit          rand_ready = 1'b0;

    always @(negedge clock_in) begin
        if (pixel_write_enable_out) begin
            mon_addr.push_back(pixel_write_address_out);
            mon_data.push_back(pixel_write_data_out);
            mon_cyc.push_back(cyc);
        end
        if (busy_out) begin
            if (mon_busy == 0) mon_busy_first = cyc;
            mon_busy++;
        end
        if (switch_write_buffer_out) begin
            if (mon_sw == 0) mon_sw_first = cyc;
            mon_sw++;
        end
        if (rand_ready) pixel_write_buffer_ready_in = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        mon_addr.delete(); mon_data.delete(); mon_cyc.delete();
        mon_busy = 0; mon_busy_first = -1; mon_sw = 0; mon_sw_first = -1;
    endtask

    task automatic strobe_op(input logic [7:0] op);
        op_code_in = op; op_code_valid_in = 1'b1;
        @(posedge clock_in); #1;
        op_code_valid_in = 1'b0;
    endtask

    task automatic strobe_operand(input logic [7:0] b);
        operand_in = b; operand_valid_in = 1'b1;
        @(posedge clock_in); #1;
        operand_valid_in = 1'b0;
    endtask

    task automatic set_cursor(input int x, input int y);
        strobe_op(8'h10);
        strobe_operand(8'(x >> 8)); strobe_operand(8'(x));
        strobe_operand(8'(y >> 8)); strobe_operand(8'(y));
        m_x = x % 1024; m_y = y % 1024;
    endtask

    task automatic set_color(input int c);
        strobe_op(8'h11); strobe_operand(8'(c));
        m_color = c % 16;
    endtask

    // Rectangle rule: row-major, optional per-pixel screen clip, address mod 2^18.
    function automatic void build_exp(input int x, input int y, input int w, input int h);
        exp_addr.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int px = x + c;
                int py = y + r;
                bit keep = 1'b1;
`ifdef PIXEL_WRITER_CLIP_EN
                if (px >= SW || py >= SH) keep = 1'b0;
`endif
                if (keep) exp_addr.push_back(18'((py * SW + px) % 262144));
            end
        end
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clock_in);
        while (busy_out && n < 5000) begin @(negedge clock_in); n++; end
        checks++;
        if (busy_out) begin
            errors++;
            $display("FAIL %s timeout: busy_out still %0b after %0d cycles, expected 0", name, busy_out, n);
        end
        repeat (2) @(negedge clock_in);
        @(posedge clock_in); #1;
    endtask

    task automatic check_fill(input string name, input int stalls, input bit timing, input int k);
        int n = exp_addr.size();
        int m = (mon_addr.size() < n) ? mon_addr.size() : n;
        checks++;
        if (mon_addr.size() != n) begin
            errors++;
            $display("FAIL %s write count: got %0d expected %0d", name, mon_addr.size(), n);
        end
        for (int i = 0; i < m; i++) begin
            checks++;
            if (mon_addr[i] !== exp_addr[i]) begin
                errors++;
                $display("FAIL %s addr[%0d]: got %0d expected %0d", name, i, mon_addr[i], exp_addr[i]);
            end
            checks++;
            if (mon_data[i] !== 4'(m_color)) begin
                errors++;
                $display("FAIL %s data[%0d]: got %0d expected %0d", name, i, mon_data[i], m_color);
            end
        end
        if (timing) begin
            int eb = (n == 0) ? 1 : n + 2 + stalls;
            checks++;
            if (mon_busy != eb) begin
                errors++;
                $display("FAIL %s busy cycles: got %0d expected %0d", name, mon_busy, eb);
            end
            checks++;
            if (mon_busy_first != k) begin
                errors++;
                $display("FAIL %s busy rise cycle: got %0d expected %0d", name, mon_busy_first, k);
            end
            if (n > 0 && mon_cyc.size() == n) begin
                checks++;
                if (mon_cyc[0] != k + 1) begin
                    errors++;
                    $display("FAIL %s first write cycle: got %0d expected %0d", name, mon_cyc[0], k + 1);
                end
                checks++;
                if (mon_cyc[n-1] - mon_cyc[0] != n - 1 + stalls) begin
                    errors++;
                    $display("FAIL %s burst span: got %0d expected %0d", name, mon_cyc[n-1] - mon_cyc[0], n - 1 + stalls);
                end
            end
        end
    endtask

    task automatic do_fill(input string name, input int w, input int h, input int stall_after, input bit timing);
        int k, stalls, seen, n;
        stalls = 0;
        build_exp(m_x, m_y, w, h);
        clear_mon();
        strobe_op(8'h12);
        strobe_operand(8'(w >> 8)); strobe_operand(8'(w));
        strobe_operand(8'(h >> 8)); strobe_operand(8'(h));
        k = cyc;
        if (stall_after > 0) begin
            seen = 0; n = 0;
            while (seen < stall_after && n < 1000) begin
                @(negedge clock_in);
                if (pixel_write_enable_out) seen++;
                n++;
            end
            checks++;
            if (seen < stall_after) begin
                errors++;
                $display("FAIL %s stall setup: got %0d writes expected %0d", name, seen, stall_after);
            end else begin
                pixel_write_buffer_ready_in = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clock_in);
                    checks++;
                    if (pixel_write_enable_out !== 1'b0) begin
                        errors++;
                        $display("FAIL %s stall enable: got %0b expected 0", name, pixel_write_enable_out);
                    end
                    checks++;
                    if (pixel_write_address_out !== exp_addr[stall_after-1]) begin
                        errors++;
                        $display("FAIL %s stall hold addr: got %0d expected %0d", name, pixel_write_address_out, exp_addr[stall_after-1]);
                    end
                end
                pixel_write_buffer_ready_in = 1'b1;
                stalls = 3;
            end
        end
        wait_idle(name);
        check_fill(name, stalls, timing, k);
    endtask

    task automatic check_outputs_zero(input string name);
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL %s busy_out: got %0b expected 0", name, busy_out); end
        checks++; if (pixel_write_address_out !== 18'd0) begin errors++; $display("FAIL %s address: got %0d expected 0", name, pixel_write_address_out); end
        checks++; if (pixel_write_data_out !== 4'd0) begin errors++; $display("FAIL %s data: got %0d expected 0", name, pixel_write_data_out); end
        checks++; if (pixel_write_enable_out !== 1'b0) begin errors++; $display("FAIL %s enable: got %0b expected 0", name, pixel_write_enable_out); end
        checks++; if (switch_write_buffer_out !== 1'b0) begin errors++; $display("FAIL %s switch: got %0b expected 0", name, switch_write_buffer_out); end
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        repeat (3) @(posedge clock_in);
        @(negedge clock_in);
        check_outputs_zero("reset");
        reset_in = 1'b0;
        m_x = 0; m_y = 0; m_color = 0;
        @(posedge clock_in); #1;
    endtask

    task automatic test_basic_fill();
        set_color(7);
        set_cursor(3, 2);
        do_fill("basic_fill", 4, 2, 0, 1'b1);
    endtask

    task automatic test_stall();
        do_fill("stall_fill", 4, 2, 2, 1'b1);
    endtask

    task automatic test_zero_and_swap();
        int k;
        do_fill("zero_w", 0, 5, 0, 1'b1);
        do_fill("zero_h", 5, 0, 0, 1'b1);
        clear_mon();
        strobe_op(8'h14);
        k = cyc;
        repeat (4) @(negedge clock_in);
        checks++;
        if (mon_sw != 1) begin errors++; $display("FAIL swap pulses: got %0d expected 1", mon_sw); end
        checks++;
        if (mon_sw_first != k) begin errors++; $display("FAIL swap cycle: got %0d expected %0d", mon_sw_first, k); end
        checks++;
        if (mon_busy != 1) begin errors++; $display("FAIL swap busy cycles: got %0d expected 1", mon_busy); end
        @(posedge clock_in); #1;
    endtask

    task automatic test_edge_fill();
        set_cursor(638, 399);
        do_fill("edge_fill", 5, 3, 0, 1'b1);
    endtask

    task automatic test_partial_ops();
        set_cursor(10, 20);
        set_color(4);
        strobe_op(8'h10);
        strobe_operand(8'h01); strobe_operand(8'h02);
        strobe_op(8'h11);
        strobe_operand(8'h0F);
        m_color = 15;
        strobe_op(8'h55);
        strobe_operand(8'h33);
        strobe_operand(8'h44);
        do_fill("partial_ops", 1, 1, 0, 1'b1);
        // Op-code and operand in the same cycle: operand dropped.
        operand_in = 8'h09; operand_valid_in = 1'b1;
        strobe_op(8'h11);
        operand_valid_in = 1'b0;
        strobe_operand(8'h02);
        m_color = 2;
        do_fill("op_beats_operand", 2, 1, 0, 1'b1);
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            int x = (it % 2 == 0) ? int'($urandom_range(0, SW - 1)) : int'($urandom_range(0, 1023));
            int y = (it % 2 == 0) ? int'($urandom_range(0, SH - 1)) : int'($urandom_range(0, 1023));
            set_cursor(x, y);
            set_color(int'($urandom_range(0, 15)));
            rand_ready = 1'b1;
            do_fill("random_fill", int'($urandom_range(0, 12)), int'($urandom_range(0, 12)), 0, 1'b0);
            rand_ready = 1'b0;
            pixel_write_buffer_ready_in = 1'b1;
            @(posedge clock_in); #1;
        end
    endtask

    task automatic test_reset_mid_fill();
        int seen = 0, n = 0;
        set_color(9);
        set_cursor(50, 60);
        strobe_op(8'h12);
        strobe_operand(8'h00); strobe_operand(8'd10);
        strobe_operand(8'h00); strobe_operand(8'd10);
        while (seen < 37 && n < 1000) begin
            @(negedge clock_in);
            if (pixel_write_enable_out) seen++;
            n++;
        end
        checks++;
        if (seen < 37) begin errors++; $display("FAIL reset_mid_fill progress: got %0d writes expected 37", seen); end
        reset_in = 1'b1;
        @(negedge clock_in);
        check_outputs_zero("reset_mid_fill");
        reset_in = 1'b0;
        m_x = 0; m_y = 0; m_color = 0;
        @(posedge clock_in); #1;
        do_fill("post_reset", 1, 1, 0, 1'b1);
    endtask

    initial begin
        @(posedge clock_in); #1;
        test_reset();
        test_basic_fill();
        test_stall();
        test_zero_and_swap();
        test_edge_fill();
        test_partial_ops();
        test_random();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
